// File: rtl/multicycle_memory.sv
// Word-addressed memory with a fixed number of wait states per access.
// The block accepts one request in IDLE and waits LATENCY cycles in WAIT.
// It then completes the access in a single RESP cycle, where ready and addr_err are valid.
module multicycle_memory #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   adr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          enter_resp;
    logic [31:0]   src_adr;
    logic          src_we;
    logic [AW-1:0] src_idx;
    logic [AW-1:0] idx_q;
    logic          err_q;

    logic [31:0] mem [DEPTH];

    // Misaligned or beyond the end of the array.
    function automatic logic adr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    // With zero wait states the load happens on the accepting edge, so the
    // live inputs must feed the read path instead of the latched request.
    assign src_adr = (state_q == IDLE) ? adr : adr_q;
    assign src_we  = (state_q == IDLE) ? we  : we_q;
    assign src_idx = src_adr[AW+1:2];
    assign idx_q   = adr_q[AW+1:2];
    assign err_q   = adr_bad(adr_q);

    // Next-state and wait counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, request latch and registered load data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                adr_q   <= adr;
                we_q    <= we;
                wdata_q <= write_data;
            end
            if (enter_resp && !src_we) begin
                rdata_q <= adr_bad(src_adr) ? 32'd0 : mem[src_idx];
            end
        end
    end

    // Store commits on the edge ending RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (rst && state_q == RESP && we_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign read_data = rdata_q;
    assign ready     = (state_q == RESP);
    assign addr_err  = ready && err_q;

endmodule

// File: doc/multicycle_memory.md
MULTICYCLE_MEMORY -- requirements
Module: multicycle_memory

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the memory size in 32-bit words (power of two, 4..4096).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait-state cycles between request acceptance and response (0..15).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit: access request from the datapath.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = write access, 0 = read access; sampled with req.
REQ-007 The block SHALL have port adr, input, 32 bits: byte address; sampled with req.
REQ-008 The block SHALL have port write_data, input, 32 bits: store data; sampled with req.
REQ-009 The block SHALL have port read_data, output, 32 bits: registered load data.
REQ-010 The block SHALL have port ready, output, 1 bit: one-cycle completion strobe.
REQ-011 The block SHALL have port addr_err, output, 1 bit: error flag, valid while ready=1.

Function
REQ-012 The FSM SHALL have three states, IDLE, WAIT and RESP, and SHALL reset to IDLE.
REQ-013 In IDLE with req=1, the block SHALL latch adr, we and write_data at the clock edge, load the wait counter with LATENCY, and go to WAIT; if LATENCY=0 it SHALL go directly to RESP.
REQ-014 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter goes from 1 to 0.
REQ-015 ready SHALL be 1 for exactly one cycle (the RESP state), which is the (LATENCY+1)th cycle after the accepting edge; RESP SHALL always return to IDLE.
REQ-016 req SHALL be ignored in WAIT and RESP: no queuing and no overwrite of the latched request.
REQ-017 A held req SHALL be re-accepted in the IDLE cycle after RESP, giving a back-to-back period of LATENCY+2 cycles.
REQ-018 The word index SHALL be latched adr[log2(DEPTH)+1:2].
REQ-019 addr_err SHALL be 1 if latched adr[1:0] != 0 or latched adr >= 4*DEPTH.
REQ-020 Read without error: read_data SHALL present mem[index] during the RESP cycle and SHALL hold that value until the next RESP.
REQ-021 Write without error: mem[index] SHALL be updated at the edge ending RESP, and read_data SHALL be unchanged.
REQ-022 On addr_err: no memory write SHALL occur, read_data SHALL be 0 for a read, and read_data SHALL be unchanged for a write.
REQ-023 addr_err SHALL be 0 whenever ready=0.
REQ-024 A read of a location written by the immediately preceding request SHALL return the new data.

Reset
REQ-025 With rst=0 at an edge: state SHALL become IDLE, the counter 0, ready 0, addr_err 0 and read_data 0.
REQ-026 Reset mid-operation (WAIT or RESP) SHALL abort the pending access with no memory write and no ready pulse.
REQ-027 Memory array contents SHALL be unaffected by reset and SHALL be undefined at power-up.
REQ-028 req sampled in the cycle where rst=0 SHALL NOT be accepted.

Verification
REQ-029 Reset then idle: rst=0 for 2 cycles, then req=0 -> ready=0, read_data=0, addr_err=0 for 10 cycles.
REQ-030 Write then read, LATENCY=2: write 0xDEADBEEF to adr 0x10, then read adr 0x10 -> each ready occurs 3 cycles after acceptance, and the read returns 0xDEADBEEF with addr_err=0.
REQ-031 Misaligned and out-of-range accesses: read adr 0x13 -> addr_err=1, read_data=0; write adr 0x400 (DEPTH=256) -> addr_err=1, and a following read of adr 0x0 is unchanged.
REQ-032 req held high for 12 cycles, LATENCY=2 -> exactly 3 ready pulses, spaced 4 cycles apart, and changes to adr/write_data during WAIT are ignored.
REQ-033 Write 0x1234 to adr 0x20 with rst=0 asserted during WAIT -> no ready pulse, and a subsequent read of 0x20 returns the prior contents (not 0x1234).
REQ-034 LATENCY=0 build: read request -> ready on the cycle immediately after acceptance, then IDLE.
